sequenciador_somas: RTL and testbench
=====================================

Name: sequenciador_somas

Overview:
- Controller that sequences the shared mixed-sign adder (`numeros_com_sinal`) through its four operation codes for one operand set.
- Accepts an operand set plus an enable mask over a valid/ready handshake, then drives `codigo` one enabled code per cycle.
- Captures each 8-bit result and presents all four together over a valid/ready output handshake.
- Sits between a command source (CPU/test FSM) and result consumers.

Parameters:
CONTADOR_W, 8, width of the completed-batch counter (wraps).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
cmd_valido  input  1  operand set present
cmd_pronto  output  1  block can accept operand set
entrada_signed_1  input  8  signed operand A
entrada_signed_2  input  4  signed operand B
entrada_unsigned_1  input  8  unsigned operand C
entrada_unsigned_2  input  4  unsigned operand D
mascara  input  4  bit n=1 runs code n (bit0=code 00 ... bit3=code 11)
resultado_valido  output  1  results available
resultado_pronto  input  1  consumer accepts results
saida_00, saida_01, saida_10, saida_11  output  8 each  captured result per code
executados  output  4  which codes were run this batch (latched mascara)
lotes  output  CONTADOR_W  count of delivered batches

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high (rst).
- Reset values: state OCIOSO; cmd_pronto=1; resultado_valido=0; saida_*=0; executados=0; lotes=0; internal code pointer=0.
- FSM states: OCIOSO, EXECUTA, ENTREGA.
- OCIOSO:
  - cmd_pronto=1.
  - On cmd_valido&&cmd_pronto: latch all four operands and mascara into registers; clear saida_*; executados<=mascara.
  - Load pointer with the lowest set mask bit, then go to EXECUTA.
  - If mascara==0: go directly to ENTREGA with all results 0.
- EXECUTA:
  - cmd_pronto=0. The adder is driven from latched operands with codigo=pointer.
  - At the clock edge, the adder output is written into saida_<pointer>.
  - Pointer advances to the next higher set mask bit.
  - After the highest set bit: go to ENTREGA.
  - Latency: popcount(mascara) cycles in EXECUTA; results visible the cycle after the last capture.
  - Disabled codes are skipped, costing 0 cycles; their outputs stay 0.
- ENTREGA:
  - resultado_valido=1; saida_* and executados held stable.
  - On resultado_pronto=1: resultado_valido<=0, lotes<=lotes+1 (wraps at 2^CONTADOR_W), go to OCIOSO.
  - cmd_pronto is high the following cycle; there is no same-cycle accept.
- Adder arithmetic (`numeros_com_sinal` datapath, all results truncated to 8 bits, no carry/overflow flags):
  - 00: A + sign-extended B.
  - 01: C + zero-extended D.
  - 10: C + A, with A's bit pattern treated as unsigned.
  - 11: C + B with B ZERO-extended. The mixed expression is unsigned, so B=4'hE adds 14, not -2.
- Operand changes on the inputs after acceptance have no effect.
- cmd_valido while not in OCIOSO is ignored; the command is not stalled into a hidden buffer.
- rst asserted in any state (including mid-EXECUTA) returns everything to reset values next edge; the partial batch is discarded and lotes is not incremented.
- resultado_pronto outside ENTREGA is ignored.

Decomposition:
- Shared package:
  - state encoding constants (OCIOSO=2'd0, EXECUTA=2'd1, ENTREGA=2'd2);
  - code constants COD_SS=2'b00, COD_UU=2'b01, COD_US8=2'b10, COD_US4=2'b11.
- One sub-module: an instance of the existing `numeros_com_sinal` as the shared adder.
- Next-set-bit pointer logic is inline.

Test Plan:
- Full mask: A=8'hFD, B=4'hE, C=8'h10, D=4'hF, mascara=4'hF -> 4 EXECUTA cycles, then saida_00=8'hFB, saida_01=8'h1F, saida_10=8'h0D, saida_11=8'h1E, executados=4'hF, lotes 0->1 on handshake.
- Sparse mask 4'b1010, same operands -> exactly 2 EXECUTA cycles; saida_01=8'h1F, saida_11=8'h1E, saida_00=saida_10=0.
- mascara=0 -> ENTREGA one cycle after accept, all saida_*=0, executados=0; lotes still increments.
- Backpressure: hold resultado_pronto=0 for 5 cycles while toggling all inputs and cmd_valido -> outputs stable, cmd_pronto=0, no new accept.
- Reset mid-EXECUTA (assert rst on 2nd execute cycle of mask 4'hF) -> next cycle all outputs 0, cmd_pronto=1, lotes unchanged.
- Counter wrap with CONTADOR_W=2: 5 back-to-back batches -> lotes sequence 1,2,3,0,1.

Source files
------------

// File: rtl/sequenciador_somas_pkg.sv
// Shared definitions for the sum sequencer: FSM state encoding, adder
// operation codes and the helpers that walk the enable mask.
package sequenciador_somas_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    EXECUTA = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  localparam logic [1:0] COD_SS  = 2'b00;  // A + sign-extended B
  localparam logic [1:0] COD_UU  = 2'b01;  // C + zero-extended D
  localparam logic [1:0] COD_US8 = 2'b10;  // C + A (A bits taken as unsigned)
  localparam logic [1:0] COD_US4 = 2'b11;  // C + zero-extended B

  // Index of the lowest set bit; returns 0 for an empty mask (caller checks).
  function automatic logic [1:0] bit_mais_baixo(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    if (m[3]) idx = 2'd3;
    if (m[2]) idx = 2'd2;
    if (m[1]) idx = 2'd1;
    if (m[0]) idx = 2'd0;
    return idx;
  endfunction

  // Mask selecting the code positions strictly above position p.
  function automatic logic [3:0] bits_acima(input logic [1:0] p);
    logic [3:0] m;
    case (p)
      2'd0:    m = 4'b1110;
      2'd1:    m = 4'b1100;
      2'd2:    m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sequenciador_somas_numeros_com_sinal.sv
// Shared mixed-sign adder. Purely combinational; every result is
// truncated to 8 bits and no carry or overflow is reported.
module numeros_com_sinal
  import sequenciador_somas_pkg::*;
(
  input  logic [7:0] entrada_signed_1,
  input  logic [3:0] entrada_signed_2,
  input  logic [7:0] entrada_unsigned_1,
  input  logic [3:0] entrada_unsigned_2,
  input  logic [1:0] codigo,
  output logic [7:0] saida
);

  // Select one of the four sums. Code 11 zero-extends B because the
  // original mixed expression evaluated as unsigned.
  always_comb begin
    saida = 8'h00;
    case (codigo)
      COD_SS:  saida = entrada_signed_1 + {{4{entrada_signed_2[3]}}, entrada_signed_2};
      COD_UU:  saida = entrada_unsigned_1 + {4'b0000, entrada_unsigned_2};
      COD_US8: saida = entrada_unsigned_1 + entrada_signed_1;
      COD_US4: saida = entrada_unsigned_1 + {4'b0000, entrada_signed_2};
      default: saida = 8'h00;
    endcase
  end

endmodule

// File: rtl/sequenciador_somas.sv
// Sum sequencer: accepts one operand set plus an enable mask, runs each
// enabled adder code once (one per cycle, disabled codes skipped), then
// presents all four results until the consumer takes them.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. cmd_pronto is high only in OCIOSO; resultado_valido is
// high only in ENTREGA. cmd_valido outside OCIOSO and resultado_pronto
// outside ENTREGA are ignored, nothing is buffered. estado exposes the
// FSM state for observation.
module sequenciador_somas
  import sequenciador_somas_pkg::*;
#(
  parameter int CONTADOR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valido,
  output logic                  cmd_pronto,
  input  logic [7:0]            entrada_signed_1,
  input  logic [3:0]            entrada_signed_2,
  input  logic [7:0]            entrada_unsigned_1,
  input  logic [3:0]            entrada_unsigned_2,
  input  logic [3:0]            mascara,
  output logic                  resultado_valido,
  input  logic                  resultado_pronto,
  output logic [7:0]            saida_00,
  output logic [7:0]            saida_01,
  output logic [7:0]            saida_10,
  output logic [7:0]            saida_11,
  output logic [3:0]            executados,
  output logic [CONTADOR_W-1:0] lotes,
  output logic [1:0]            estado
);

  estado_t               estado_q, estado_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [7:0]            a_q, a_d;
  logic [3:0]            b_q, b_d;
  logic [7:0]            c_q, c_d;
  logic [3:0]            d_q, d_d;
  logic [3:0]            exec_q, exec_d;
  logic [7:0]            saida_q [4];
  logic [7:0]            saida_d [4];
  logic [CONTADOR_W-1:0] lotes_q, lotes_d;
  logic [3:0]            resto;
  logic [7:0]            soma;

  // The adder always sees the latched operands; only the pointer changes.
  numeros_com_sinal u_somador (
    .entrada_signed_1   (a_q),
    .entrada_signed_2   (b_q),
    .entrada_unsigned_1 (c_q),
    .entrada_unsigned_2 (d_q),
    .codigo             (ptr_q),
    .saida              (soma)
  );

  // Next-state logic: accept, walk the mask one set bit per cycle, deliver.
  always_comb begin
    estado_d = estado_q;
    ptr_d    = ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    exec_d   = exec_q;
    saida_d  = saida_q;
    lotes_d  = lotes_q;
    resto    = exec_q & bits_acima(ptr_q);
    case (estado_q)
      OCIOSO: begin
        if (cmd_valido) begin
          a_d    = entrada_signed_1;
          b_d    = entrada_signed_2;
          c_d    = entrada_unsigned_1;
          d_d    = entrada_unsigned_2;
          exec_d = mascara;
          for (int i = 0; i < 4; i++) saida_d[i] = 8'h00;
          ptr_d    = bit_mais_baixo(mascara);
          estado_d = (mascara == 4'b0000) ? ENTREGA : EXECUTA;
        end
      end
      EXECUTA: begin
        saida_d[ptr_q] = soma;
        if (resto == 4'b0000) begin
          estado_d = ENTREGA;
        end else begin
          ptr_d = bit_mais_baixo(resto);
        end
      end
      ENTREGA: begin
        if (resultado_pronto) begin
          lotes_d  = lotes_q + CONTADOR_W'(1);
          estado_d = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      ptr_q    <= 2'd0;
      a_q      <= 8'h00;
      b_q      <= 4'h0;
      c_q      <= 8'h00;
      d_q      <= 4'h0;
      exec_q   <= 4'h0;
      for (int i = 0; i < 4; i++) saida_q[i] <= 8'h00;
      lotes_q  <= '0;
    end else begin
      estado_q <= estado_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      exec_q   <= exec_d;
      saida_q  <= saida_d;
      lotes_q  <= lotes_d;
    end
  end

  assign cmd_pronto       = (estado_q == OCIOSO);
  assign resultado_valido = (estado_q == ENTREGA);
  assign saida_00         = saida_q[0];
  assign saida_01         = saida_q[1];
  assign saida_10         = saida_q[2];
  assign saida_11         = saida_q[3];
  assign executados       = exec_q;
  assign lotes            = lotes_q;
  assign estado           = estado_q;

endmodule

// File: tb/tb_sequenciador_somas.sv
// Directed bench for sequenciador_somas, built with a 2-bit batch counter
// so that five delivered batches walk lotes through 1,2,3,0,1.
module tb_sequenciador_somas;

  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          cmd_valido;
  logic          cmd_pronto;
  logic [7:0]    entrada_signed_1;
  logic [3:0]    entrada_signed_2;
  logic [7:0]    entrada_unsigned_1;
  logic [3:0]    entrada_unsigned_2;
  logic [3:0]    mascara;
  logic          resultado_valido;
  logic          resultado_pronto;
  logic [7:0]    saida_00, saida_01, saida_10, saida_11;
  logic [3:0]    executados;
  logic [CW-1:0] lotes;
  logic [1:0]    estado;

  int total;
  int passed;
  int n_exec;

  sequenciador_somas #(.CONTADOR_W(CW)) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valido         (cmd_valido),
    .cmd_pronto         (cmd_pronto),
    .entrada_signed_1   (entrada_signed_1),
    .entrada_signed_2   (entrada_signed_2),
    .entrada_unsigned_1 (entrada_unsigned_1),
    .entrada_unsigned_2 (entrada_unsigned_2),
    .mascara            (mascara),
    .resultado_valido   (resultado_valido),
    .resultado_pronto   (resultado_pronto),
    .saida_00           (saida_00),
    .saida_01           (saida_01),
    .saida_10           (saida_10),
    .saida_11           (saida_11),
    .executados         (executados),
    .lotes              (lotes),
    .estado             (estado)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, count the pass, report a miss.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_saidas(input string tag, input logic [7:0] e00, input logic [7:0] e01,
                            input logic [7:0] e10, input logic [7:0] e11, input logic [3:0] ex);
    chk({tag, "_s00"}, {24'h0, saida_00}, {24'h0, e00});
    chk({tag, "_s01"}, {24'h0, saida_01}, {24'h0, e01});
    chk({tag, "_s10"}, {24'h0, saida_10}, {24'h0, e10});
    chk({tag, "_s11"}, {24'h0, saida_11}, {24'h0, e11});
    chk({tag, "_exec"}, {28'h0, executados}, {28'h0, ex});
  endtask

  // Present a command while idle; it is taken on the next edge.
  task automatic enviar(input logic [7:0] a, input logic [3:0] b, input logic [7:0] c,
                        input logic [3:0] d, input logic [3:0] m);
    entrada_signed_1   = a;
    entrada_signed_2   = b;
    entrada_unsigned_1 = c;
    entrada_unsigned_2 = d;
    mascara            = m;
    cmd_valido         = 1'b1;
    step();
    cmd_valido = 1'b0;
    // Scramble the inputs: latched operands must not follow them.
    entrada_signed_1   = 8'($urandom_range(0, 255));
    entrada_signed_2   = 4'($urandom_range(0, 15));
    entrada_unsigned_1 = 8'($urandom_range(0, 255));
    entrada_unsigned_2 = 4'($urandom_range(0, 15));
    mascara            = 4'($urandom_range(0, 15));
  endtask

  // Count cycles spent in EXECUTA until results appear (bounded).
  task automatic esperar_resultado(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (resultado_valido) break;
      if (estado == 2'd1) n++;
      step();
    end
  endtask

  task automatic entregar(input string tag, input logic [CW-1:0] lotes_exp);
    resultado_pronto = 1'b1;
    step();
    resultado_pronto = 1'b0;
    chk({tag, "_valido_baixo"}, {31'h0, resultado_valido}, 32'h0);
    chk({tag, "_pronto_alto"}, {31'h0, cmd_pronto}, 32'h1);
    chk({tag, "_lotes"}, {30'h0, lotes}, {30'h0, lotes_exp});
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    cmd_valido = 1'b0;
    resultado_pronto = 1'b0;
    entrada_signed_1 = 8'h00;
    entrada_signed_2 = 4'h0;
    entrada_unsigned_1 = 8'h00;
    entrada_unsigned_2 = 4'h0;
    mascara = 4'h0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_estado", {30'h0, estado}, 32'h0);
    chk("rst_cmd_pronto", {31'h0, cmd_pronto}, 32'h1);
    chk("rst_valido", {31'h0, resultado_valido}, 32'h0);
    chk("rst_lotes", {30'h0, lotes}, 32'h0);
    chk_saidas("rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);

    // resultado_pronto while idle is ignored
    resultado_pronto = 1'b1;
    step();
    resultado_pronto = 1'b0;
    chk("idle_pronto_lotes", {30'h0, lotes}, 32'h0);
    chk("idle_pronto_estado", {30'h0, estado}, 32'h0);

    // Reset in the second execute cycle discards the batch
    enviar(8'hFD, 4'hE, 8'h10, 4'hF, 4'hF);
    chk("rst_mid_exec1", {30'h0, estado}, 32'h1);
    step();
    chk("rst_mid_exec2", {30'h0, estado}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_estado", {30'h0, estado}, 32'h0);
    chk("rst_mid_cmd_pronto", {31'h0, cmd_pronto}, 32'h1);
    chk("rst_mid_valido", {31'h0, resultado_valido}, 32'h0);
    chk("rst_mid_lotes", {30'h0, lotes}, 32'h0);
    chk_saidas("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);

    // Full mask: FD+FE=FB, 10+0F=1F, 10+FD=0D, 10+0E=1E
    enviar(8'hFD, 4'hE, 8'h10, 4'hF, 4'hF);
    esperar_resultado(n_exec);
    chk("cheia_ciclos", n_exec, 32'd4);
    chk("cheia_valido", {31'h0, resultado_valido}, 32'h1);
    chk("cheia_cmd_pronto", {31'h0, cmd_pronto}, 32'h0);
    chk_saidas("cheia", 8'hFB, 8'h1F, 8'h0D, 8'h1E, 4'hF);
    entregar("cheia", 2'd1);

    // Sparse mask 1010: only codes 01 and 11
    enviar(8'hFD, 4'hE, 8'h10, 4'hF, 4'b1010);
    esperar_resultado(n_exec);
    chk("esparsa_ciclos", n_exec, 32'd2);
    chk_saidas("esparsa", 8'h00, 8'h1F, 8'h00, 8'h1E, 4'hA);
    entregar("esparsa", 2'd2);

    // Empty mask: straight to delivery on the cycle after accept
    enviar(8'h55, 4'h5, 8'h66, 4'h6, 4'h0);
    chk("vazia_valido_imediato", {31'h0, resultado_valido}, 32'h1);
    esperar_resultado(n_exec);
    chk("vazia_ciclos", n_exec, 32'd0);
    chk_saidas("vazia", 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    entregar("vazia", 2'd3);

    // Backpressure: mask 0101, 7F+03=82, F0+7F=6F (16F truncated)
    enviar(8'h7F, 4'h3, 8'hF0, 4'h1, 4'b0101);
    esperar_resultado(n_exec);
    chk("contra_ciclos", n_exec, 32'd2);
    for (int k = 0; k < 5; k++) begin
      cmd_valido         = (k % 2 == 0);
      entrada_signed_1   = 8'($urandom_range(0, 255));
      entrada_signed_2   = 4'($urandom_range(0, 15));
      entrada_unsigned_1 = 8'($urandom_range(0, 255));
      entrada_unsigned_2 = 4'($urandom_range(0, 15));
      mascara            = 4'($urandom_range(0, 15));
      step();
      chk("contra_valido", {31'h0, resultado_valido}, 32'h1);
      chk("contra_cmd_pronto", {31'h0, cmd_pronto}, 32'h0);
      chk_saidas("contra", 8'h82, 8'h00, 8'h6F, 8'h00, 4'h5);
    end
    cmd_valido = 1'b0;
    entregar("contra", 2'd0);
    chk("contra_sem_aceite", {30'h0, estado}, 32'h0);

    // Fifth batch: counter continues after the wrap
    enviar(8'h01, 4'h8, 8'h80, 4'h7, 4'b0001);
    esperar_resultado(n_exec);
    chk("quinto_ciclos", n_exec, 32'd1);
    chk_saidas("quinto", 8'hF9, 8'h00, 8'h00, 8'h00, 4'h1);
    entregar("quinto", 2'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
